// File: rtl/viterbi_decoder_pkg.sv
// Shared definitions for the hard-decision Viterbi decoder: code limits,
// FSM state encoding and the Hamming branch-metric helper.
package viterbi_decoder_pkg;

  localparam int MAX_CODE_RATE         = 3;
  localparam int MAX_CONSTRAINT_LENGTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACS   = 2'd1,
    ST_TRACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // sr must be zero above bit K-1 so that unused polynomial bits drop out.
  function automatic logic [1:0] branch_metric(
    input logic [MAX_CONSTRAINT_LENGTH-1:0]               sr,
    input logic [MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH-1:0] polys,
    input logic                                           rate,
    input logic [MAX_CODE_RATE-1:0]                       rx
  );
    logic [1:0] bm;
    bm = '0;
    for (int j = 0; j < MAX_CODE_RATE; j++) begin
      if (j < 2 || rate) begin
        bm = bm + {1'b0, (^(sr & polys[j*MAX_CONSTRAINT_LENGTH +: MAX_CONSTRAINT_LENGTH])) ^ rx[j]};
      end
    end
    return bm;
  endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Single-state add-compare-select: picks the cheaper of two incoming
// branches; ties resolve to predecessor b=0.
module viterbi_acs_unit #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [1:0]      i_bm0,
  input  logic [1:0]      i_bm1,
  output logic [PM_W-1:0] o_pm,
  output logic            o_dec
);

  logic [PM_W-1:0] w_sum0;
  logic [PM_W-1:0] w_sum1;

  assign w_sum0 = i_pm0 + {{(PM_W-2){1'b0}}, i_bm0};
  assign w_sum1 = i_pm1 + {{(PM_W-2){1'b0}}, i_bm1};
  assign o_dec  = (w_sum1 < w_sum0);
  assign o_pm   = o_dec ? w_sum1 : w_sum0;

endmodule

// File: rtl/viterbi_decoder.sv
// Frame-based hard-decision Viterbi decoder: per-symbol ACS over all states,
// survivor storage, then a FRAME_LEN-cycle traceback from state 0.
module viterbi_decoder
  import viterbi_decoder_pkg::*;
#(
  parameter int K         = 3,
  parameter int FRAME_LEN = 32,
  parameter int PM_W      = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_code_rate,
  input  logic [MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly,
  input  logic                                           i_rx_valid,
  input  logic [MAX_CODE_RATE-1:0]                       i_rx_sym,
  output logic                                           o_rx_ready,
  output logic [FRAME_LEN-1:0]                           o_dec_data,
  output logic [PM_W-1:0]                                o_dec_metric,
  output logic                                           o_dec_done
);

  localparam int NS = 1 << (K - 1);
  localparam int TW = $clog2(FRAME_LEN);
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  state_t               r_state;
  logic                 r_ready;
  logic [TW-1:0]        r_t;
  logic [K-2:0]         r_tb_state;
  logic [FRAME_LEN-1:0] r_dec_work;
  logic [FRAME_LEN-1:0] r_dec_data;
  logic [PM_W-1:0]      r_dec_metric;
  logic                 r_done;
  logic [NS-1:0]        r_surv [FRAME_LEN];

  logic [PM_W-1:0]      w_pm [NS];
  logic [NS-1:0]        w_dec;
  logic                 w_hs;
  logic                 w_tb_bit;

  assign w_hs         = i_rx_valid & r_ready;
  assign w_tb_bit     = r_surv[r_t][r_tb_state];
  assign o_rx_ready   = r_ready & ~rst;
  assign o_dec_data   = r_dec_data;
  assign o_dec_metric = r_dec_metric;
  assign o_dec_done   = r_done;

  // Both branches into state s share input bit s[K-2]; the register
  // contents along branch b are therefore {s, b}.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_state
      localparam logic [PM_W-1:0] PM_RST = (gi == 0) ? '0 : PM_INIT;
      logic [PM_W-1:0] r_pm;
      logic [PM_W-1:0] w_pm_next;
      logic [1:0]      w_bm0;
      logic [1:0]      w_bm1;

      assign w_bm0 = branch_metric(MAX_CONSTRAINT_LENGTH'(2 * gi), i_gen_poly, i_code_rate, i_rx_sym);
      assign w_bm1 = branch_metric(MAX_CONSTRAINT_LENGTH'(2 * gi + 1), i_gen_poly, i_code_rate, i_rx_sym);

      viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
        .i_pm0 (w_pm[(2 * gi) % NS]),
        .i_pm1 (w_pm[(2 * gi + 1) % NS]),
        .i_bm0 (w_bm0),
        .i_bm1 (w_bm1),
        .o_pm  (w_pm_next),
        .o_dec (w_dec[gi])
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pm <= PM_RST;
        end else if (r_state == ST_DONE) begin
          r_pm <= PM_RST;
        end else if (w_hs) begin
          r_pm <= w_pm_next;
        end
      end

      assign w_pm[gi] = r_pm;
    end
  endgenerate

  // Survivor memory keeps its contents across reset; every row is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_surv[r_t] <= w_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_t          <= '0;
      r_tb_state   <= '0;
      r_dec_work   <= '0;
      r_dec_data   <= '0;
      r_dec_metric <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_t     <= r_t + 1'b1;
            r_state <= ST_ACS;
          end
        end
        ST_ACS: begin
          if (w_hs) begin
            if (r_t == TW'(FRAME_LEN - 1)) begin
              r_tb_state <= '0;
              r_ready    <= 1'b0;
              r_state    <= ST_TRACE;
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        ST_TRACE: begin
          r_dec_work[r_t] <= r_tb_state[K-2];
          r_tb_state      <= {r_tb_state[K-3:0], w_tb_bit};
          if (r_t == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_t <= r_t - 1'b1;
          end
        end
        ST_DONE: begin
          r_dec_data   <= r_dec_work;
          r_dec_metric <= w_pm[0];
          r_done       <= 1'b1;
          r_t          <= '0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench: frames are built by a behavioural convolutional
// encoder; expected decode is the original info bits, metric the flip count.
module tb_viterbi_decoder;
  import viterbi_decoder_pkg::*;

  localparam int K    = 3;
  localparam int FL   = 32;
  localparam int PM_W = 8;
  localparam int MCL  = MAX_CONSTRAINT_LENGTH;
  localparam int MCR  = MAX_CODE_RATE;
  localparam int P0   = 7;  // 3'b111
  localparam int P1   = 5;  // 3'b101
  localparam int P2   = 3;  // 3'b011

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_code_rate;
  logic [MCR*MCL-1:0]   i_gen_poly;
  logic                 i_rx_valid;
  logic [MCR-1:0]       i_rx_sym;
  logic                 o_rx_ready;
  logic [FL-1:0]        o_dec_data;
  logic [PM_W-1:0]      o_dec_metric;
  logic                 o_dec_done;

  int checks = 0;
  int errors = 0;
  logic [2:0] tx_sym [FL];

  viterbi_decoder #(.K(K), .FRAME_LEN(FL), .PM_W(PM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_code_rate  (i_code_rate),
    .i_gen_poly   (i_gen_poly),
    .i_rx_valid   (i_rx_valid),
    .i_rx_sym     (i_rx_sym),
    .o_rx_ready   (o_rx_ready),
    .o_dec_data   (o_dec_data),
    .o_dec_metric (o_dec_metric),
    .o_dec_done   (o_dec_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Shift-register encoder: sr = {in, state}, out_j = parity(sr & poly_j).
  task automatic encode(input logic [FL-1:0] info, input logic rate);
    int s;
    int sr;
    s = 0;
    for (int t = 0; t < FL; t++) begin
      sr = (int'(info[t]) << (K - 1)) | s;
      tx_sym[t][0] = 1'($countones(sr & P0) % 2);
      tx_sym[t][1] = 1'($countones(sr & P1) % 2);
      tx_sym[t][2] = rate ? 1'($countones(sr & P2) % 2) : 1'b0;
      s = sr >> 1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [FL-1:0] info, input logic rate,
                           input int flip_sym, input int flip_bit, input int stall_pct);
    int idx;
    int cyc;
    int lat;
    int ready_hi;
    int exp_metric;
    logic v;
    logic rdy;
    i_code_rate = rate;
    encode(info, rate);
    exp_metric = 0;
    if (flip_sym >= 0) begin
      tx_sym[flip_sym][flip_bit] = ~tx_sym[flip_sym][flip_bit];
      exp_metric = 1;
    end
    idx = 0;
    cyc = 0;
    while (idx < FL && cyc < 3000) begin
      @(negedge clk);
      v = ($urandom_range(0, 99) >= stall_pct);
      i_rx_valid = v;
      i_rx_sym = v ? tx_sym[idx] : 3'($urandom);
      rdy = o_rx_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      cyc++;
    end
    check({tag, "_accepted"}, 64'(idx), 64'(FL));
    lat = -1;
    ready_hi = 0;
    for (int c = 0; c <= FL + 8; c++) begin
      @(negedge clk);
      if (o_dec_done) begin
        lat = c;
        break;
      end
      ready_hi += int'(o_rx_ready);
      i_rx_valid = 1'b1;
      i_rx_sym = 3'($urandom);
    end
    i_rx_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(FL + 1));
    check({tag, "_ready_in_trace"}, 64'(ready_hi), 64'd0);
    check({tag, "_data"}, 64'(o_dec_data), 64'(info));
    check({tag, "_metric"}, 64'(o_dec_metric), 64'(exp_metric));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(o_dec_done), 64'd0);
    check({tag, "_data_hold"}, 64'(o_dec_data), 64'(info));
    $display("frame %s: info=%08h rate=%0d flip=%0d lat=%0d data=%08h metric=%0d",
             tag, info, rate, flip_sym, lat, o_dec_data, o_dec_metric);
  endtask

  initial begin
    logic [FL-1:0] info;
    logic          rate;
    int            fs;
    int            fb;
    rst = 1'b1;
    i_code_rate = 1'b0;
    i_gen_poly = {MCL'(P2), MCL'(P1), MCL'(P0)};
    i_rx_valid = 1'b0;
    i_rx_sym = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(o_rx_ready), 64'd0);
    check("rst_data", 64'(o_dec_data), 64'd0);
    check("rst_metric", 64'(o_dec_metric), 64'd0);
    check("rst_done", 64'(o_dec_done), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(o_rx_ready), 64'd1);

    run_frame("zeros", '0, 1'b0, -1, 0, 0);
    run_frame("d1011", FL'(32'hD), 1'b0, -1, 0, 0);
    run_frame("d1011_err", FL'(32'hD), 1'b0, 2, 0, 0);
    run_frame("d1011_stall", FL'(32'hD), 1'b0, -1, 0, 30);
    run_frame("r13_1011", FL'(32'hD), 1'b1, -1, 0, 0);

    for (int n = 0; n < 6; n++) begin
      info = {{(K-1){1'b0}}, (FL-K+1)'($urandom)};
      rate = 1'($urandom);
      fs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FL - 1)) : -1;
      fb = int'($urandom_range(0, rate ? 2 : 1));
      run_frame($sformatf("rand%0d", n), info, rate, fs, fb, 20);
    end

    // Abort a frame at t=10 with an asynchronous reset.
    i_code_rate = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      i_rx_valid = 1'b1;
      i_rx_sym = '0;
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(o_rx_ready), 64'd0);
    check("midrst_data", 64'(o_dec_data), 64'd0);
    check("midrst_metric", 64'(o_dec_metric), 64'd0);
    check("midrst_done", 64'(o_dec_done), 64'd0);
    $display("mid-frame reset: ready=%0d data=%08h metric=%0d", o_rx_ready, o_dec_data, o_dec_metric);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 64'(o_rx_ready), 64'd1);
    run_frame("post_rst_zeros", '0, 1'b0, -1, 0, 0);
    run_frame("post_rst_d1011", FL'(32'hD), 1'b0, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
